// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store path: access size codes and
// the load/store unit state machine.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        LSU_IDLE   = 3'd0,
        LSU_RD     = 3'd1,
        LSU_WR     = 3'd2,
        LSU_RMW_RD = 3'd3,
        LSU_RMW_WR = 3'd4,
        LSU_RESP   = 3'd5
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering: pulls a byte/half out of a memory word (with sign or
// zero extension) and splices store data into a memory word.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_extract,
    output logic [31:0] o_merge
);

    // Offset 0 is the most significant lane, so the shift is (3-off) bytes.
    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bsh  = {~i_off, 3'b000};
    assign w_hsh  = {~i_off[1], 4'b0000};
    assign w_byte = 8'(i_word >> w_bsh);
    assign w_half = 16'(i_word >> w_hsh);

    always_comb begin
        o_extract = i_word;
        o_merge   = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_extract = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_merge   = (i_word & ~(32'h0000_00FF << w_bsh))
                          | ({24'h0, i_wdata[7:0]} << w_bsh);
            end
            SZ_HALF: begin
                o_extract = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_merge   = (i_word & ~(32'h0000_FFFF << w_hsh))
                          | ({16'h0, i_wdata[15:0]} << w_hsh);
            end
            default: begin
                o_extract = i_word;
                o_merge   = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for data_memory: sequences read / write / read-modify-write
// accesses and holds the pipeline stalled until each one completes.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    input  logic [31:0] mem_readData
);

    lsu_state_t  r_state;
    logic [29:0] r_word_addr;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_resp_data;

    logic        w_idle;
    logic        w_busy;
    logic        w_bad;
    logic        w_accept;
    logic [31:0] w_lane_word;
    logic [31:0] w_extract;
    logic [31:0] w_merge;

    assign w_idle = (r_state == LSU_IDLE);
    assign w_busy = (r_state == LSU_RD) || (r_state == LSU_WR)
                 || (r_state == LSU_RMW_RD) || (r_state == LSU_RMW_WR);

    // Range test is on the enclosing aligned word, so every lane of it must exist.
    assign w_bad = (req_size == SZ_RSVD)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || ({req_addr[31:2], 2'b00} > 32'(MEM_BYTES - 4));

    assign fault    = w_idle && req_valid && w_bad;
    assign w_accept = w_idle && req_valid && !w_bad;
    assign stall    = w_busy || w_accept;

    assign resp_valid    = (r_state == LSU_RESP);
    assign resp_data     = r_resp_data;
    assign mem_address   = {r_word_addr, 2'b00};
    assign mem_memRead   = (r_state == LSU_RD) || (r_state == LSU_RMW_RD);
    assign mem_memWrite  = (r_state == LSU_WR) || (r_state == LSU_RMW_WR);
    assign mem_writeData = (r_state == LSU_RMW_WR) ? w_merge
                         : (r_state == LSU_WR)     ? r_wdata : 32'h0;

    // One aligner serves both paths: live read data for loads, merge word for RMW.
    assign w_lane_word = (r_state == LSU_RMW_WR) ? r_merge : mem_readData;

    lsu_lane_align u_align (
        .i_word     (w_lane_word),
        .i_wdata    (r_wdata),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_extract  (w_extract),
        .o_merge    (w_merge)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_word_addr <= req_addr[31:2];
            r_off       <= req_addr[1:0];
            r_size      <= req_size;
            r_uns       <= req_unsigned;
            r_wdata     <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LSU_IDLE;
            r_resp_data <= '0;
            r_merge     <= '0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        if (!req_write)              r_state <= LSU_RD;
                        else if (req_size == SZ_WORD) r_state <= LSU_WR;
                        else                          r_state <= LSU_RMW_RD;
                    end
                end
                LSU_RD: begin
                    r_resp_data <= w_extract;
                    r_state     <= LSU_RESP;
                end
                LSU_RMW_RD: begin
                    r_merge <= mem_readData;
                    r_state <= LSU_RMW_WR;
                end
                LSU_RMW_WR, LSU_WR: begin
                    r_resp_data <= '0;
                    r_state     <= LSU_RESP;
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-array memory model predicts every
// cycle of each access, and a single compare process checks the DUT against it.
module tb_load_store_unit;

    localparam int MEM_BYTES = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        fault;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_readData;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .fault        (fault),
        .mem_address  (mem_address),
        .mem_writeData(mem_writeData),
        .mem_memWrite (mem_memWrite),
        .mem_memRead  (mem_memRead),
        .mem_readData (mem_readData)
    );

    // data_memory responder: combinational read, negedge write.
    logic [31:0] ram [0:MEM_BYTES/4-1];
    assign mem_readData = mem_memRead ? ram[mem_address[6:2]] : 32'h0;
    always @(negedge clk) if (mem_memWrite) ram[mem_address[6:2]] <= mem_writeData;

    // Reference memory, one entry per byte.
    logic [7:0] mdl [0:MEM_BYTES-1];

    typedef struct {
        string       tag;
        logic        stall, rd, wr, rv, flt, chk_data;
        logic [31:0] data, wdata, addr;
    } exp_t;

    exp_t q[$];
    exp_t ce;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic ok;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            ok = (stall == ce.stall) && (mem_memRead == ce.rd) && (mem_memWrite == ce.wr)
              && (resp_valid == ce.rv) && (fault == ce.flt);
            if (ce.rd || ce.wr) ok = ok && (mem_address == ce.addr);
            if (ce.wr)          ok = ok && (mem_writeData == ce.wdata);
            if (ce.rv || ce.chk_data) ok = ok && (resp_data == ce.data);
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL cyc%0d %s: got stall=%b rd=%b wr=%b rv=%b flt=%b addr=%h wd=%h rdata=%h; required stall=%b rd=%b wr=%b rv=%b flt=%b addr=%h wd=%h rdata=%h",
                          cyc, ce.tag, stall, mem_memRead, mem_memWrite, resp_valid, fault,
                          mem_address, mem_writeData, resp_data,
                          ce.stall, ce.rd, ce.wr, ce.rv, ce.flt, ce.addr, ce.wdata, ce.data);
        end
    end

    task automatic push(input string t, input logic s, input logic rd, input logic wr,
                        input logic rv, input logic flt, input logic chk,
                        input logic [31:0] d, input logic [31:0] wd, input logic [31:0] ad);
        exp_t e;
        e.tag = t; e.stall = s; e.rd = rd; e.wr = wr; e.rv = rv; e.flt = flt;
        e.chk_data = chk; e.data = d; e.wdata = wd; e.addr = ad;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_fault(input logic [1:0] sz, input logic [31:0] a);
        longint base;
        base = longint'(a) - longint'(a % 4);
        if (sz == 2'b11) return 1'b1;
        if ((a % (32'd1 << sz)) != 0) return 1'b1;
        return (base + 4) > MEM_BYTES;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int          n;
        logic [31:0] v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mdl[a + i]};
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 1);
        return v;
    endfunction

    // Drives one request and queues the expected behaviour of every cycle it spans.
    // rst_at selects the busy cycle (0-based) during which reset is asserted, or -1.
    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input int rst_at,
                           input logic chk_lit, input logic [31:0] lit);
        int          n, nbusy, base;
        logic [7:0]  b [4];
        logic [31:0] newword, ldval, aw;
        logic        brd, bwr;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        if (is_fault(sz, a)) begin
            push({tag, " fault"}, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            step();
            req_valid = 1'b0;
            push({tag, " after-fault"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
            return;
        end
        n     = 1 << sz;
        base  = int'(a) - int'(a % 4);
        aw    = 32'(base);
        ldval = wr ? 32'h0 : model_load(sz, uns, a);
        for (int i = 0; i < 4; i++) b[i] = mdl[base + i];
        for (int i = 0; i < n; i++) b[int'(a % 4) + i] = wd[8*(n-1-i) +: 8];
        newword = {b[0], b[1], b[2], b[3]};
        if (chk_lit) begin
            n_checks++;
            if ((wr ? newword : ldval) == lit) n_pass++;
            else $display("FAIL %s model: got %h required %h", tag, wr ? newword : ldval, lit);
        end
        nbusy = (wr && sz != 2'b10) ? 2 : 1;
        push({tag, " accept"}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        // Scramble the request bus: the unit must work from its latched copy.
        req_addr = ~a; req_wdata = ~wd; req_size = ~sz; req_write = ~wr;
        for (int k = 0; k < nbusy; k++) begin
            brd = !wr || (sz != 2'b10 && k == 0);
            bwr = wr && (sz == 2'b10 || k == 1);
            push({tag, " busy"}, 1, brd, bwr, 0, 0, 0, 0, newword, aw);
            if (rst_at == k) rst = 1'b1;
            step();
            if (bwr) for (int i = 0; i < 4; i++) mdl[base + i] = b[i];
            if (rst_at == k) begin
                rst = 1'b0; req_valid = 1'b0;
                push({tag, " after-rst"}, 0, 0, 0, 0, 0, 1, 0, 0, 0);
                step();
                return;
            end
        end
        req_valid = 1'b0;
        push({tag, " resp"}, 0, 0, 0, 1, 0, 0, ldval, 0, 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_BYTES / 4; i++) ram[i] = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++) mdl[i] = 8'h0;
        ram[4]  = 32'h8899AABB;
        mdl[16] = 8'h88; mdl[17] = 8'h99; mdl[18] = 8'hAA; mdl[19] = 8'hBB;
        ram[31] = 32'h11223344;
        mdl[124] = 8'h11; mdl[125] = 8'h22; mdl[126] = 8'h33; mdl[127] = 8'h44;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        step();
        step();
        rst = 1'b0;
        push("reset", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step();

        run_req("lb 0x11",  0, 2'b00, 0, 32'h11, 0, -1, 1, 32'hFFFFFF99);
        run_req("lbu 0x11", 0, 2'b00, 1, 32'h11, 0, -1, 1, 32'h00000099);
        run_req("lh 0x12",  0, 2'b01, 0, 32'h12, 0, -1, 1, 32'hFFFFAABB);
        run_req("lhu 0x10", 0, 2'b01, 1, 32'h10, 0, -1, 1, 32'h00008899);
        run_req("lw 0x10",  0, 2'b10, 0, 32'h10, 0, -1, 1, 32'h8899AABB);
        run_req("lb 0x13",  0, 2'b00, 0, 32'h13, 0, -1, 1, 32'hFFFFFFBB);
        run_req("sb 0x13",  1, 2'b00, 0, 32'h13, 32'h12345655, -1, 1, 32'h8899AA55);
        run_req("lw 0x10b", 0, 2'b10, 0, 32'h10, 0, -1, 1, 32'h8899AA55);
        run_req("sh 0x10",  1, 2'b01, 0, 32'h10, 32'h0000CAFE, -1, 1, 32'hCAFEAA55);
        run_req("lw 0x10c", 0, 2'b10, 0, 32'h10, 0, -1, 1, 32'hCAFEAA55);
        run_req("sw 0x20",  1, 2'b10, 0, 32'h20, 32'hDEADBEEF, -1, 1, 32'hDEADBEEF);
        run_req("lw 0x20",  0, 2'b10, 0, 32'h20, 0, -1, 1, 32'hDEADBEEF);

        run_req("lh 0x11",  0, 2'b01, 0, 32'h11, 0, -1, 0, 0);
        run_req("lw 0x12",  0, 2'b10, 0, 32'h12, 0, -1, 0, 0);
        run_req("size11",   0, 2'b11, 0, 32'h10, 0, -1, 0, 0);
        run_req("lw 0x7C",  0, 2'b10, 0, 32'h7C, 0, -1, 1, 32'h11223344);
        run_req("lw 0x80",  0, 2'b10, 0, 32'h80, 0, -1, 0, 0);
        run_req("sb 0x80",  1, 2'b00, 0, 32'h80, 32'h1, -1, 0, 0);

        run_req("sb rst@rd", 1, 2'b00, 0, 32'h10, 32'h00000077, 0, 0, 0);
        run_req("lw 0x10d",  0, 2'b10, 0, 32'h10, 0, -1, 1, 32'hCAFEAA55);
        run_req("sb rst@wr", 1, 2'b00, 0, 32'h10, 32'h00000077, 1, 1, 32'h77FEAA55);
        run_req("lw 0x10e",  0, 2'b10, 0, 32'h10, 0, -1, 1, 32'h77FEAA55);
        run_req("sw rst@wr", 1, 2'b10, 0, 32'h24, 32'h0BADF00D, 0, 1, 32'h0BADF00D);
        run_req("lw 0x24",   0, 2'b10, 0, 32'h24, 0, -1, 1, 32'h0BADF00D);
        run_req("lbu 0x25",  0, 2'b00, 1, 32'h25, 0, -1, 1, 32'h000000AD);

        push("idle tail", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL queue drain: got %0d pending required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
